// File: rtl/cache_nway_wb_ctrl.sv
// N-way set-associative, write-back, write-allocate cache controller with a
// full-cache flush command. Tag, data, valid, dirty and replacement state are
// kept in internal registers.
//
// Handshakes: the CPU side is a request/stall interface (cpu_cs is held stable
// while cpu_hold=1; a read hit returns cpu_rdata in the request cycle). The
// memory side is request/ack: mem_cs, mem_rw, mem_addr and mem_wdata stay
// stable from state entry until the one-cycle mem_ack, and mem_cs drops in the
// cycle after the ack.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_addr/cs/rw/wdata  CPU request (word address, valid, 0=read 1=write)
//   cpu_rdata, cpu_hold   read data (valid on an unheld read), CPU stall
//   flush_req, flush_done start flush (sampled in IDLE), completion pulse
//   mem_addr/cs/rw/wdata  block request to main memory (block aligned)
//   mem_rdata, mem_ack    fill data and completion pulse from memory
//   dbg_state             current FSM state for observation
module cache_nway_wb_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int WORD_WIDTH     = 32,
   parameter int CACHE_SIZE     = 256,
   parameter int BLOCK_SIZE     = 2,
   parameter int NUMBER_OF_SETS = 4,
   parameter int REPL_POLICY    = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [ADDR_WIDTH-1:0]            cpu_addr,
   input  logic                             cpu_cs,
   input  logic                             cpu_rw,
   input  logic [WORD_WIDTH-1:0]            cpu_wdata,
   output logic [WORD_WIDTH-1:0]            cpu_rdata,
   output logic                             cpu_hold,
   input  logic                             flush_req,
   output logic                             flush_done,
   output logic [ADDR_WIDTH-1:0]            mem_addr,
   output logic                             mem_cs,
   output logic                             mem_rw,
   output logic [WORD_WIDTH*BLOCK_SIZE-1:0] mem_wdata,
   input  logic [WORD_WIDTH*BLOCK_SIZE-1:0] mem_rdata,
   input  logic                             mem_ack,
   output logic [2:0]                       dbg_state
);
   localparam int LINES        = CACHE_SIZE / (BLOCK_SIZE * NUMBER_OF_SETS);
   localparam int OFFSET_WIDTH = $clog2(BLOCK_SIZE);
   localparam int LINE_WIDTH   = $clog2(LINES);
   localparam int TAG_WIDTH    = ADDR_WIDTH - LINE_WIDTH - OFFSET_WIDTH;
   localparam int TAG_LSB      = LINE_WIDTH + OFFSET_WIDTH;
   // Zero-width fields (direct-mapped, single-word blocks, single line) are
   // carried as 1-bit signals that are tied to zero.
   localparam int OW      = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;
   localparam int LW      = (LINE_WIDTH > 0) ? LINE_WIDTH : 1;
   localparam int WAY_W   = (NUMBER_OF_SETS > 1) ? $clog2(NUMBER_OF_SETS) : 1;
   localparam int BLK_W   = WORD_WIDTH * BLOCK_SIZE;
   localparam int ENTRIES = LINES * NUMBER_OF_SETS;
   localparam int IDX_W   = $clog2(ENTRIES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE_BACK, S_ALLOCATE, S_FLUSH_SCAN, S_FLUSH_WB
   } state_t;

   state_t r_state, w_next;

   logic             r_valid [NUMBER_OF_SETS][LINES];
   logic             r_dirty [NUMBER_OF_SETS][LINES];
   logic [TAG_WIDTH-1:0] r_tag [NUMBER_OF_SETS][LINES];
   logic [BLK_W-1:0] r_data  [NUMBER_OF_SETS][LINES];
   logic [WAY_W-1:0] r_age   [NUMBER_OF_SETS][LINES];
   logic [WAY_W-1:0] r_rr    [LINES];

   logic [WAY_W-1:0]     r_victim;
   logic [LW-1:0]        r_line;
   logic [TAG_WIDTH-1:0] r_req_tag;
   logic [IDX_W-1:0]     r_fl_idx;

   logic [TAG_WIDTH-1:0]  w_tag;
   logic [LW-1:0]         w_line;
   logic [OW-1:0]         w_off;
   logic                  w_hit, w_inv_found;
   logic [WAY_W-1:0]      w_hit_way, w_inv_way, w_lru_way, w_victim;
   logic [BLK_W-1:0]      w_hit_blk;
   logic [WORD_WIDTH-1:0] w_hit_word;
   logic                  w_acc_hit, w_fill, w_upd_en, w_fl_end;
   logic [WAY_W-1:0]      w_upd_way, w_fl_way;
   logic [LW-1:0]         w_upd_line, w_fl_line;

   function automatic logic [ADDR_WIDTH-1:0] blk_addr(input logic [TAG_WIDTH-1:0] t,
                                                      input logic [LW-1:0] l);
      return (ADDR_WIDTH'(t) << TAG_LSB) | (ADDR_WIDTH'(l) << OFFSET_WIDTH);
   endfunction

   assign w_tag  = TAG_WIDTH'(cpu_addr >> TAG_LSB);
   assign w_line = (LINE_WIDTH == 0) ? '0 : LW'(cpu_addr >> OFFSET_WIDTH);
   assign w_off  = (OFFSET_WIDTH == 0) ? '0 : OW'(cpu_addr);

   // Flush walks entries line-major, way-minor: idx = line*N + way.
   assign w_fl_way  = WAY_W'(r_fl_idx % IDX_W'(NUMBER_OF_SETS));
   assign w_fl_line = (LINE_WIDTH == 0) ? '0 : LW'(r_fl_idx / IDX_W'(NUMBER_OF_SETS));
   assign w_fl_end  = (r_fl_idx == IDX_W'(ENTRIES));

   always_comb begin : lookup
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_lru_way   = '0;
      for (int w = 0; w < NUMBER_OF_SETS; w++) begin
         if (r_valid[w][w_line] && (r_tag[w][w_line] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!w_inv_found && !r_valid[w][w_line]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
         // Ages form a permutation per line; the oldest way holds N-1.
         if (r_age[w][w_line] == WAY_W'(NUMBER_OF_SETS - 1))
            w_lru_way = WAY_W'(w);
      end
      if (w_inv_found)           w_victim = w_inv_way;
      else if (REPL_POLICY == 0) w_victim = w_lru_way;
      else                       w_victim = r_rr[w_line];
      w_hit_blk  = r_data[w_hit_way][w_line];
      w_hit_word = w_hit_blk[int'(w_off)*WORD_WIDTH +: WORD_WIDTH];
   end

   assign w_acc_hit  = (r_state == S_IDLE) && cpu_cs && w_hit;
   assign w_fill     = (r_state == S_ALLOCATE) && mem_ack;
   assign w_upd_en   = w_acc_hit || w_fill;
   assign w_upd_way  = w_acc_hit ? w_hit_way : r_victim;
   assign w_upd_line = w_acc_hit ? w_line : r_line;
   assign dbg_state  = r_state;

   always_comb begin : fsm_comb
      w_next     = r_state;
      cpu_hold   = 1'b0;
      cpu_rdata  = '0;
      flush_done = 1'b0;
      mem_cs     = 1'b0;
      mem_rw     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (r_state)
         S_IDLE: begin
            if (cpu_cs) begin
               if (w_hit) begin
                  if (!cpu_rw) cpu_rdata = w_hit_word;
               end else begin
                  cpu_hold = 1'b1;
                  w_next = (r_valid[w_victim][w_line] && r_dirty[w_victim][w_line])
                           ? S_WRITE_BACK : S_ALLOCATE;
               end
            end else if (flush_req) begin
               w_next = S_FLUSH_SCAN;
            end
         end
         S_WRITE_BACK: begin
            cpu_hold  = cpu_cs;
            mem_cs    = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = blk_addr(r_tag[r_victim][r_line], r_line);
            mem_wdata = r_data[r_victim][r_line];
            if (mem_ack) w_next = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            cpu_hold = cpu_cs;
            mem_cs   = 1'b1;
            mem_addr = blk_addr(r_req_tag, r_line);
            if (mem_ack) w_next = S_IDLE;
         end
         S_FLUSH_SCAN: begin
            cpu_hold = cpu_cs;
            if (w_fl_end) begin
               flush_done = 1'b1;
               w_next     = S_IDLE;
            end else if (r_dirty[w_fl_way][w_fl_line]) begin
               w_next = S_FLUSH_WB;
            end
         end
         S_FLUSH_WB: begin
            cpu_hold  = cpu_cs;
            mem_cs    = 1'b1;
            mem_rw    = 1'b1;
            mem_addr  = blk_addr(r_tag[w_fl_way][w_fl_line], w_fl_line);
            mem_wdata = r_data[w_fl_way][w_fl_line];
            if (mem_ack) w_next = S_FLUSH_SCAN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_victim  <= '0;
         r_line    <= '0;
         r_req_tag <= '0;
         r_fl_idx  <= '0;
         for (int l = 0; l < LINES; l++) begin
            r_rr[l] <= '0;
            for (int w = 0; w < NUMBER_OF_SETS; w++) begin
               r_valid[w][l] <= 1'b0;
               r_dirty[w][l] <= 1'b0;
               r_age[w][l]   <= WAY_W'(w);
            end
         end
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (cpu_cs) begin
                  if (w_hit) begin
                     if (cpu_rw) r_dirty[w_hit_way][w_line] <= 1'b1;
                  end else begin
                     r_victim  <= w_victim;
                     r_line    <= w_line;
                     r_req_tag <= w_tag;
                  end
               end else if (flush_req) begin
                  r_fl_idx <= '0;
               end
            end
            S_WRITE_BACK: if (mem_ack) r_dirty[r_victim][r_line] <= 1'b0;
            S_ALLOCATE: begin
               if (mem_ack) begin
                  r_valid[r_victim][r_line] <= 1'b1;
                  r_dirty[r_victim][r_line] <= 1'b0;
                  if (REPL_POLICY != 0)
                     r_rr[r_line] <= (r_rr[r_line] == WAY_W'(NUMBER_OF_SETS - 1))
                                     ? '0 : r_rr[r_line] + 1'b1;
               end
            end
            S_FLUSH_SCAN: begin
               if (!w_fl_end && !r_dirty[w_fl_way][w_fl_line]) r_fl_idx <= r_fl_idx + 1'b1;
            end
            S_FLUSH_WB: begin
               if (mem_ack) begin
                  r_dirty[w_fl_way][w_fl_line] <= 1'b0;
                  r_fl_idx <= r_fl_idx + 1'b1;
               end
            end
            default: ;
         endcase
         // Touched way becomes youngest; ways younger than it age by one.
         if (w_upd_en && (REPL_POLICY == 0)) begin
            for (int w = 0; w < NUMBER_OF_SETS; w++) begin
               if (WAY_W'(w) == w_upd_way)
                  r_age[w][w_upd_line] <= '0;
               else if (r_age[w][w_upd_line] < r_age[w_upd_way][w_upd_line])
                  r_age[w][w_upd_line] <= r_age[w][w_upd_line] + 1'b1;
            end
         end
      end
   end

   // Payload storage needs no reset: it is only observable through valid bits.
   always_ff @(posedge clk) begin
      if (w_acc_hit && cpu_rw)
         r_data[w_hit_way][w_line][int'(w_off)*WORD_WIDTH +: WORD_WIDTH] <= cpu_wdata;
      if (w_fill) begin
         r_data[r_victim][r_line] <= mem_rdata;
         r_tag[r_victim][r_line]  <= r_req_tag;
      end
   end
endmodule

// File: tb/tb_cache_nway_wb_ctrl.sv
module tb_cache_nway_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_cs = 1'b0;
   logic        cpu_rw = 1'b0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_hold;
   logic        flush_req = 1'b0;
   logic        flush_done;
   logic [31:0] mem_addr;
   logic        mem_cs, mem_rw;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   cache_nway_wb_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
      .flush_req(flush_req), .flush_done(flush_done), .mem_addr(mem_addr),
      .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Backing memory (written only by DUT write-backs) and the architectural
   // memory image every CPU read must observe.
   logic [31:0] bmem  [1024];
   logic [31:0] truth [1024];
   logic [32:0] exp_q [$];
   logic [32:0] obs_q [$];
   int          delay_max = 0;
   int          delay_cnt = 0;
   bit          resp_en = 1'b1;
   logic [31:0] last_wb_w0 = '0;

   // Reference cache: per (way,line) presence with last-use timestamps.
   bit m_valid [4][32];
   bit m_dirty [4][32];
   int m_tag   [4][32];
   int m_stamp [4][32];
   int now_t;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mem_service();
      logic [31:0] a;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (resp_en && mem_cs) begin
         if (delay_cnt > 0) begin
            delay_cnt--;
         end else begin
            a = mem_addr;
            if (mem_rw) begin
               bmem[a[9:0]]       = mem_wdata[31:0];
               bmem[a[9:0] + 1]   = mem_wdata[63:32];
               last_wb_w0         = mem_wdata[31:0];
            end else begin
               mem_rdata = {bmem[a[9:0] + 1], bmem[a[9:0]]};
            end
            obs_q.push_back({mem_rw, a});
            mem_ack   = 1'b1;
            delay_cnt = $urandom_range(0, delay_max);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mem_service();
      #1;
   endtask

   task automatic model_reset();
      for (int w = 0; w < 4; w++)
         for (int l = 0; l < 32; l++) begin
            m_valid[w][l] = 1'b0;
            m_dirty[w][l] = 1'b0;
            m_tag[w][l]   = 0;
            m_stamp[w][l] = -w - 1;
         end
      now_t = 0;
      for (int i = 0; i < 1024; i++) truth[i] = bmem[i];
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic model_access(input logic [31:0] a, input bit rw, input logic [31:0] wd,
                               output bit miss);
      int line, tag, way, best;
      logic [31:0] ba;
      line = int'((a >> 1) & 32'd31);
      tag  = int'(a >> 6);
      way  = -1;
      for (int w = 0; w < 4; w++)
         if (m_valid[w][line] && m_tag[w][line] == tag) way = w;
      miss = (way < 0);
      if (miss) begin
         for (int w = 3; w >= 0; w--)
            if (!m_valid[w][line]) way = w;
         if (way < 0) begin
            best = 0;
            for (int w = 1; w < 4; w++)
               if (m_stamp[w][line] < m_stamp[best][line]) best = w;
            way = best;
            if (m_dirty[way][line]) begin
               ba = 32'(m_tag[way][line] * 64 + line * 2);
               exp_q.push_back({1'b1, ba});
            end
         end
         ba = a & ~32'd1;
         exp_q.push_back({1'b0, ba});
         m_valid[way][line] = 1'b1;
         m_dirty[way][line] = 1'b0;
         m_tag[way][line]   = tag;
      end
      now_t++;
      m_stamp[way][line] = now_t;
      if (rw) begin
         m_dirty[way][line] = 1'b1;
         truth[a[9:0]] = wd;
      end
   endtask

   task automatic model_flush();
      logic [31:0] ba;
      for (int l = 0; l < 32; l++)
         for (int w = 0; w < 4; w++)
            if (m_dirty[w][l]) begin
               ba = 32'(m_tag[w][l] * 64 + l * 2);
               exp_q.push_back({1'b1, ba});
               m_dirty[w][l] = 1'b0;
            end
   endtask

   task automatic check_ops(input string tag);
      logic [32:0] e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
         chk(tag, o, e);
      end
      chk({tag, "_extra"}, obs_q.size(), 0);
      obs_q.delete();
   endtask

   task automatic access(input logic [31:0] a, input bit rw, input logic [31:0] wd,
                         output logic [31:0] rd, output bit stalled);
      int held;
      cpu_addr = a; cpu_rw = rw; cpu_wdata = wd; cpu_cs = 1'b1;
      #1;
      held = 0;
      while (cpu_hold && held < 300) begin
         held++;
         tick();
      end
      if (held >= 300) chk("access_timeout", cpu_hold, 0);
      stalled = (held > 0);
      rd = cpu_rdata;
      tick();
      cpu_cs = 1'b0;
   endtask

   task automatic do_access(input logic [31:0] a, input bit rw, input logic [31:0] wd,
                            output bit stalled, output logic [31:0] rd);
      bit miss;
      logic [31:0] exp_rd;
      exp_rd = truth[a[9:0]];
      model_access(a, rw, wd, miss);
      access(a, rw, wd, rd, stalled);
      chk("hit_miss", stalled, miss);
      if (!rw) chk("rdata", rd, exp_rd);
      check_ops("mem_ops");
   endtask

   task automatic do_flush(output int cycles);
      model_flush();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      cycles = 1;
      while (!flush_done && cycles < 5000) begin
         tick();
         cycles++;
      end
      chk("flush_done_seen", flush_done, 1);
      tick();
      chk("flush_done_pulse", flush_done, 0);
   endtask

   task automatic do_reset();
      cpu_cs = 1'b0; flush_req = 1'b0; mem_ack = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          st;
      logic [31:0] rd, a, d;
      int          cyc, bad, pick;
      int          line_pool [4];
      line_pool = '{0, 1, 2, 31};
      for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
      bmem[16] = 32'hAAAA;
      bmem[17] = 32'hBBBB;

      // Reset state
      #2;
      chk("rst_hold", cpu_hold, 0);
      chk("rst_mem_cs", mem_cs, 0);
      chk("rst_mem_rw", mem_rw, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", cpu_rdata, 0);
      tick();
      rst_n = 1'b1;
      tick();
      model_reset();

      // Cold read miss, then neighbour word hits
      do_access(32'h10, 1'b0, 0, st, rd);
      chk("t1_stall", st, 1);
      chk("t1_rdata", rd, 32'hAAAA);
      do_access(32'h11, 1'b0, 0, st, rd);
      chk("t1_nostall", st, 0);
      chk("t1_rdata2", rd, 32'hBBBB);

      // Write hit
      do_access(32'h10, 1'b1, 32'h1234, st, rd);
      chk("t2_wr_nostall", st, 0);
      do_access(32'h10, 1'b0, 0, st, rd);
      chk("t2_rd", rd, 32'h1234);

      // LRU eviction of the oldest way
      do_access(32'h00, 1'b0, 0, st, rd);
      do_access(32'h40, 1'b0, 0, st, rd);
      do_access(32'h80, 1'b0, 0, st, rd);
      do_access(32'hC0, 1'b0, 0, st, rd);
      chk("t3_fill4", st, 1);
      do_access(32'h40, 1'b0, 0, st, rd);
      chk("t3_hit40", st, 0);
      do_access(32'h100, 1'b0, 0, st, rd);
      chk("t3_miss100", st, 1);
      do_access(32'h40, 1'b0, 0, st, rd);
      chk("t3_rehit40", st, 0);
      do_access(32'h80, 1'b0, 0, st, rd);
      chk("t3_hit80", st, 0);
      do_access(32'hC0, 1'b0, 0, st, rd);
      chk("t3_hitC0", st, 0);
      do_flush(cyc);
      check_ops("t3_flush_ops");
      do_reset();

      // Dirty eviction
      do_access(32'h00, 1'b1, 32'hDEAD, st, rd);
      do_access(32'h40, 1'b0, 0, st, rd);
      do_access(32'h80, 1'b0, 0, st, rd);
      do_access(32'hC0, 1'b0, 0, st, rd);
      do_access(32'h100, 1'b0, 0, st, rd);
      chk("t4_wb_word0", last_wb_w0, 32'hDEAD);
      chk("t4_bmem0", bmem[0], 32'hDEAD);

      // Flush: clean everything, then exactly two dirty blocks
      do_flush(cyc);
      check_ops("t5_pre_flush_ops");
      do_access(32'h02, 1'b1, 32'h0202_0202, st, rd);
      do_access(32'h84, 1'b1, 32'h8484_8484, st, rd);
      do_flush(cyc);
      chk("t5_n_writes", obs_q.size(), 2);
      chk("t5_first_wr", obs_q[0], {1'b1, 32'h02});
      check_ops("t5_flush_ops");
      do_flush(cyc);
      chk("t5_clean_writes", obs_q.size(), 0);
      chk("t5_clean_cycles", cyc, 129);
      check_ops("t5_clean_ops");

      // Randomized traffic with variable memory latency
      delay_max = 3;
      for (int i = 0; i < 400; i++) begin
         pick = $urandom_range(0, 49);
         if (pick == 0) begin
            do_flush(cyc);
            check_ops("rnd_flush_ops");
         end else begin
            a = 32'($urandom_range(0, 7) * 64 + line_pool[$urandom_range(0, 3)] * 2
                    + $urandom_range(0, 1));
            d = $urandom;
            do_access(a, 1'($urandom_range(0, 1)), d, st, rd);
         end
      end
      do_flush(cyc);
      check_ops("final_flush_ops");
      bad = 0;
      for (int i = 0; i < 1024; i++) if (bmem[i] !== truth[i]) bad++;
      chk("final_mem_image", bad, 0);

      // Reset in the middle of an allocate
      delay_max = 0;
      resp_en = 1'b0;
      cpu_addr = 32'h30; cpu_rw = 1'b0; cpu_cs = 1'b1;
      tick();
      chk("t6_mem_cs", mem_cs, 1);
      chk("t6_mem_addr", mem_addr, 32'h30);
      chk("t6_mem_rw", mem_rw, 0);
      #2;
      rst_n = 1'b0;
      cpu_cs = 1'b0;
      #1;
      chk("t6_async_cs", mem_cs, 0);
      chk("t6_async_state", dbg_state, 0);
      tick();
      rst_n = 1'b1;
      tick();
      mem_rdata = '1;
      mem_ack = 1'b1;
      tick();
      chk("t6_late_ack_state", dbg_state, 0);
      chk("t6_late_ack_cs", mem_cs, 0);
      resp_en = 1'b1;
      model_reset();
      do_access(32'h30, 1'b0, 0, st, rd);
      chk("t6_remiss", st, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cache_nway_wb_ctrl.md
Name: cache_nway_wb_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller between the CPU data port and block-wide main memory. It generalises the existing fixed cache configuration in several ways: way count, block size, capacity and widths are all parameters; replacement is true LRU (selectable round-robin); and it adds a full-cache flush command. Tag/data/valid/dirty arrays are internal registers.

Parameters:
ADDR_WIDTH, 32, word-address width.
WORD_WIDTH, 32, data word width.
CACHE_SIZE, 256, capacity in words (power of 2).
BLOCK_SIZE, 2, words per block (power of 2, >=1).
NUMBER_OF_SETS, 4, associativity (ways, power of 2, >=1).
REPL_POLICY, 0, 0 = true LRU via per-line age counters; 1 = per-line round-robin pointer.
Derived: LINES_PER_SET = CACHE_SIZE/(BLOCK_SIZE*NUMBER_OF_SETS); OFFSET_WIDTH = clog2(BLOCK_SIZE); LINE_WIDTH = clog2(LINES_PER_SET); TAG_WIDTH = ADDR_WIDTH-LINE_WIDTH-OFFSET_WIDTH.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
cpu_addr  in  ADDR_WIDTH  word address.
cpu_cs  in  1  request valid.
cpu_rw  in  1  0 = read, 1 = write.
cpu_wdata  in  WORD_WIDTH  write data.
cpu_rdata  out  WORD_WIDTH  read data; valid when cpu_cs & !cpu_rw & !cpu_hold.
cpu_hold  out  1  stall CPU.
flush_req  in  1  start flush (level-sampled in IDLE).
flush_done  out  1  one-cycle pulse when flush completes.
mem_addr  out  ADDR_WIDTH  block-aligned address (offset bits 0).
mem_cs  out  1  memory request, held until ack.
mem_rw  out  1  0 = block read, 1 = block write.
mem_wdata  out  WORD_WIDTH*BLOCK_SIZE  block data, word 0 in LSBs.
mem_rdata  in  WORD_WIDTH*BLOCK_SIZE  fill data, valid with mem_ack.
mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Address split: tag = [MSB:TAG_LSB], line = next LINE_WIDTH bits, offset = low OFFSET_WIDTH bits.
- Reset (async assert, sync deassert): all valid=0, dirty=0; LRU age of way i = i; RR pointer = 0. Outputs: cpu_hold=0, mem_cs=0, mem_rw=0, flush_done=0, mem_addr=0, cpu_rdata=0.
- FSM states: IDLE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- IDLE, cpu_cs=1: the tag compare across all ways is combinational.
  - Hit: cpu_hold=0 in the same cycle (0-wait-state).
  - Read hit: cpu_rdata = the selected word in the same cycle.
  - Write hit: word written at the clock edge; dirty=1.
  - Any hit updates replacement state.
- Miss: cpu_hold=1 combinationally in that cycle.
  - Victim selection: lowest-index invalid way; otherwise LRU way (age = NUMBER_OF_SETS-1) or the RR pointer. The victim is latched.
  - Next state is WRITE_BACK if the victim is valid & dirty, else ALLOCATE.
- WRITE_BACK: mem_cs=1, mem_rw=1, mem_addr = {victim tag, line, 0}, mem_wdata = victim block. On mem_ack: dirty=0, go to ALLOCATE.
- ALLOCATE: mem_cs=1, mem_rw=0, mem_addr = {req tag, line, 0}. On mem_ack: write mem_rdata into the victim way, set tag, valid=1, dirty=0, go to IDLE.
  - The request is re-evaluated in IDLE and hits (one extra cycle). A write miss completes as a write hit there.
- Memory request: mem_cs and mem_addr are stable from state entry until the ack cycle. mem_cs drops in the cycle after mem_ack.
- LRU update on hit or fill of way w with age a: every way in the line with age < a increments; way w gets age 0. RR mode: the pointer advances (mod NUMBER_OF_SETS) on fill only.
- Flush: in IDLE with cpu_cs=0 and flush_req=1, go to FLUSH_SCAN. cpu_cs has priority over flush_req in the same cycle.
  - FLUSH_SCAN visits (line, way) in order line-major, way-minor, one entry per cycle. A dirty entry goes to FLUSH_WB (same protocol as WRITE_BACK), then clears dirty and resumes at the next entry.
  - After the last entry: flush_done=1 for one cycle, go to IDLE. Valid bits are kept.
  - During flush, cpu_hold=1 whenever cpu_cs=1.
- cpu_hold=1 in every non-IDLE state while cpu_cs=1. CPU inputs must remain stable while held.
- mem_ack outside WRITE_BACK/ALLOCATE/FLUSH_WB is ignored.
- Reset mid-transaction: the FSM returns to IDLE, mem_cs drops immediately (async), and all lines are invalidated. The in-flight fill is discarded.
- Degenerate NUMBER_OF_SETS=1 (direct-mapped) and BLOCK_SIZE=1 (OFFSET_WIDTH=0) must elaborate and work.

Test Plan:
Defaults (32 lines/way, stride 64 words maps to the same line).
1. Cold read miss: read 0x10 → mem_cs, mem_rw=0, mem_addr=0x10; ack with {0xBBBB,0xAAAA} → one cycle later cpu_hold=0, cpu_rdata=0xAAAA. Read 0x11 → 0xBBBB with no stall.
2. Write hit: write 0x10 ← 0x1234 → no stall; read 0x10 = 0x1234; no memory traffic.
3. LRU eviction: read 0x00, 0x40, 0x80, 0xC0, read 0x40 again, read 0x100 → fill into the way holding 0x00 (no write-back). A re-read of 0x40 still hits.
4. Dirty eviction: write 0x00 ← 0xDEAD, then miss on 0x40, 0x80, 0xC0, 0x100 → a WRITE_BACK to mem_addr=0x00 with word0=0xDEAD precedes the 0x100 fill.
5. Flush: dirty lines at 0x02 and 0x84 → flush_req → exactly two block writes (0x02 then 0x84), then a flush_done pulse. A second flush produces zero writes and flush_done after 128 scan cycles.
6. Reset mid-ALLOCATE: deassert rst_n while mem_cs=1 → mem_cs=0 immediately. After release, read of the same address misses again, and a late mem_ack is ignored.
